// File: rtl/frame_compositor_pkg.sv
// Shared types and width helpers for the double-buffered frame compositor.
package frame_compositor_pkg;

  typedef enum logic [1:0] {
    ST_DONE  = 2'd0,
    ST_BG    = 2'd1,
    ST_LAYER = 2'd2,
    ST_DRAIN = 2'd3
  } comp_state_e;

  localparam int LX_W   = 10;
  localparam int LY_W   = 10;
  localparam int POS_W  = 11;
  localparam int DROP_W = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_compositor_vram_dp_pair.sv
// Two frame buffers: the read port always sees the front buffer, the write
// port always lands in the back buffer.
module vram_dp_pair
  import frame_compositor_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          front_sel,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem_a [2**AW];
  logic [DW-1:0] mem_b [2**AW];

  // front_sel = 0: A is displayed and B is drawn into.
  always_ff @(posedge CLK) begin
    if (we && front_sel)  mem_a[wr_addr] <= wr_data;
    if (we && !front_sel) mem_b[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (rd_en) rd_data <= front_sel ? mem_b[rd_addr] : mem_a[rd_addr];
  end

endmodule

// File: rtl/frame_compositor.sv
// Layer compositor: tiles a background sprite, overlays alpha-keyed sprite
// layers into the back buffer and scans the front buffer out as palette indices.
module frame_compositor
  import frame_compositor_pkg::*;
#(
  parameter int SCREEN_W     = 320,
  parameter int SCREEN_H     = 180,
  parameter int SPRITE_S     = 32,
  parameter int SPRITE_COUNT = 8,
  parameter int NUM_LAYERS   = 8,
  parameter int PIX_W        = 8,
  parameter int VRAM_AW      = 16,
  parameter int SPR_AW       = 13
) (
  input  logic                                   CLK,
  input  logic                                   rst,
  input  logic                                   pix_stb,
  input  logic [9:0]                             i_x,
  input  logic [8:0]                             i_y,
  input  logic                                   i_active,
  input  logic                                   i_screenend,
  input  logic [$clog2(SPRITE_COUNT)-1:0]        i_bg_idx,
  input  logic [NUM_LAYERS-1:0]                  i_layer_en,
  input  logic [LX_W*NUM_LAYERS-1:0]             i_layer_x,
  input  logic [LY_W*NUM_LAYERS-1:0]             i_layer_y,
  input  logic [$clog2(SPRITE_COUNT)*NUM_LAYERS-1:0] i_layer_idx,
  output logic [SPR_AW-1:0]                      o_spr_addr,
  input  logic [PIX_W-1:0]                       i_spr_data,
  input  logic                                   i_spr_alpha,
  output logic [PIX_W-1:0]                       o_pix_idx,
  output logic                                   o_frame_valid,
  output logic                                   o_busy,
  output logic                                   o_frame_drop,
  output logic [DROP_W-1:0]                      o_drop_cnt
);

  localparam int IDX_W  = $clog2(SPRITE_COUNT);
  localparam int SB     = $clog2(SPRITE_S);
  localparam int KW     = clog2_min1(NUM_LAYERS);
  localparam int SPR_SZ = SPRITE_S * SPRITE_S;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  comp_state_e state_q, state_d;
  logic [9:0]    cx_q, cx_d;
  logic [8:0]    cy_q, cy_d;
  logic [SB-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [KW-1:0] k_q, k_d;

  logic              front_sel_q, frame_valid_q, done_once_q, drop_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [IDX_W-1:0]  bg_q;
  logic [NUM_LAYERS-1:0] en_q;
  logic [LX_W-1:0]   lx_q   [NUM_LAYERS];
  logic [LY_W-1:0]   ly_q   [NUM_LAYERS];
  logic [IDX_W-1:0]  lidx_q [NUM_LAYERS];

  logic              cur_en;
  logic [LX_W-1:0]   cur_lx;
  logic [LY_W-1:0]   cur_ly;
  logic [IDX_W-1:0]  cur_idx;

  logic               issue, issue_bg, tgt_in;
  logic [POS_W-1:0]   tgt_x, tgt_y;
  logic [SPR_AW-1:0]  spr_addr_c;
  logic [VRAM_AW-1:0] tgt_addr_c;

  logic               vld_p0, bg_p0, wr_en;
  logic [VRAM_AW-1:0] wr_addr_p0;

  logic               swap_ev, scan_in, pix_vld_p0;
  logic [VRAM_AW-1:0] rd_addr;
  logic [PIX_W-1:0]   rd_data;

  assign swap_ev = pix_stb && i_screenend;
  assign cur_en  = en_q[k_q];
  assign cur_lx  = lx_q[k_q];
  assign cur_ly  = ly_q[k_q];
  assign cur_idx = lidx_q[k_q];

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    k_d        = k_q;
    issue      = 1'b0;
    issue_bg   = 1'b0;
    spr_addr_c = '0;
    tgt_x      = '0;
    tgt_y      = '0;
    unique case (state_q)
      ST_DONE: begin
        if (swap_ev) begin
          state_d = ST_BG;
          cx_d    = '0;
          cy_d    = '0;
          sx_d    = '0;
          sy_d    = '0;
          k_d     = '0;
        end
      end
      ST_BG: begin
        issue      = 1'b1;
        issue_bg   = 1'b1;
        spr_addr_c = SPR_AW'(int'(bg_q) * SPR_SZ + int'(cy_q[SB-1:0]) * SPRITE_S
                             + int'(cx_q[SB-1:0]));
        tgt_x      = POS_W'(cx_q);
        tgt_y      = POS_W'(cy_q);
        if (int'(cx_q) == SCREEN_W - 1) begin
          cx_d = '0;
          if (int'(cy_q) == SCREEN_H - 1) begin
            state_d = ST_LAYER;
            k_d     = '0;
            sx_d    = '0;
            sy_d    = '0;
          end else begin
            cy_d = cy_q + 9'd1;
          end
        end else begin
          cx_d = cx_q + 10'd1;
        end
      end
      ST_LAYER: begin
        if (cur_en) begin
          issue      = 1'b1;
          spr_addr_c = SPR_AW'(int'(cur_idx) * SPR_SZ + int'(sy_q) * SPRITE_S + int'(sx_q));
          // 11-bit sums so a sprite hanging off the right edge never wraps.
          tgt_x      = POS_W'(cur_lx) + POS_W'(sx_q);
          tgt_y      = POS_W'(cur_ly) + POS_W'(sy_q);
          sx_d       = sx_q + SB'(1);
          if (&sx_q) sy_d = sy_q + SB'(1);
        end
        if (!cur_en || (&sx_q && &sy_q)) begin
          sx_d = '0;
          sy_d = '0;
          if (int'(k_q) == NUM_LAYERS - 1) state_d = ST_DRAIN;
          else                             k_d     = k_q + KW'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_DONE;
      cx_q    <= '0;
      cy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      front_sel_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      done_once_q   <= 1'b0;
      drop_q        <= 1'b0;
      drop_cnt_q    <= '0;
      bg_q          <= '0;
      en_q          <= '0;
      for (int j = 0; j < NUM_LAYERS; j++) begin
        lx_q[j]   <= '0;
        ly_q[j]   <= '0;
        lidx_q[j] <= '0;
      end
    end else begin
      drop_q <= swap_ev && (state_q != ST_DONE);
      if (swap_ev && (state_q != ST_DONE)) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (state_q == ST_DRAIN) done_once_q <= 1'b1;
      if (swap_ev && (state_q == ST_DONE)) begin
        front_sel_q   <= ~front_sel_q;
        frame_valid_q <= frame_valid_q | done_once_q;
        bg_q          <= i_bg_idx;
        en_q          <= i_layer_en;
        for (int j = 0; j < NUM_LAYERS; j++) begin
          lx_q[j]   <= i_layer_x[j*LX_W +: LX_W];
          ly_q[j]   <= i_layer_y[j*LY_W +: LY_W];
          lidx_q[j] <= i_layer_idx[j*IDX_W +: IDX_W];
        end
      end
    end
  end

  assign tgt_in     = (int'(tgt_x) < SCREEN_W) && (int'(tgt_y) < SCREEN_H);
  assign tgt_addr_c = VRAM_AW'(int'(tgt_y) * SCREEN_W + int'(tgt_x));

  // Stage p0: sprite fetch in flight, target address held until the ROM answers
  always_ff @(posedge CLK) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      bg_p0  <= 1'b0;
    end else begin
      vld_p0 <= issue && tgt_in;
      bg_p0  <= issue_bg;
    end
  end

  always_ff @(posedge CLK) begin
    wr_addr_p0 <= tgt_addr_c;
  end

  // Stage p1: write-back; background ignores alpha
  assign wr_en = vld_p0 && (bg_p0 || i_spr_alpha);

  assign scan_in = (int'(i_x) < SCREEN_W) && (int'(i_y) < SCREEN_H);
  assign rd_addr = scan_in ? VRAM_AW'(int'(i_y) * SCREEN_W + int'(i_x)) : '0;

  // Scan stage p0: fetch on one strobe, present on the next
  always_ff @(posedge CLK) begin
    if (rst) begin
      pix_vld_p0 <= 1'b0;
      o_pix_idx  <= '0;
    end else if (pix_stb) begin
      pix_vld_p0 <= i_active && frame_valid_q && scan_in;
      o_pix_idx  <= pix_vld_p0 ? rd_data : '0;
    end
  end

  vram_dp_pair #(
    .AW (VRAM_AW),
    .DW (PIX_W)
  ) u_vram (
    .CLK       (CLK),
    .front_sel (front_sel_q),
    .rd_en     (pix_stb),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .we        (wr_en),
    .wr_addr   (wr_addr_p0),
    .wr_data   (i_spr_data)
  );

  assign o_spr_addr    = spr_addr_c;
  assign o_frame_valid = frame_valid_q;
  assign o_busy        = (state_q != ST_DONE);
  assign o_frame_drop  = drop_q;
  assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frame_compositor.sv
// Scoreboard bench for frame_compositor on a reduced 64x64 screen with 32x32 sprites.
module tb_frame_compositor;

  localparam int W = 64, H = 64, S = 32, SC = 8, NL = 8, PW = 8, VAW = 12, SAW = 13;

  logic           CLK = 1'b0;
  logic           rst, pix_stb, i_active, i_screenend;
  logic [9:0]     i_x;
  logic [8:0]     i_y;
  logic [2:0]     i_bg_idx;
  logic [NL-1:0]  i_layer_en;
  logic [10*NL-1:0] i_layer_x, i_layer_y;
  logic [3*NL-1:0]  i_layer_idx;
  logic [SAW-1:0] o_spr_addr;
  logic [PW-1:0]  spr_data, o_pix_idx;
  logic           spr_alpha, o_frame_valid, o_busy, o_frame_drop;
  logic [7:0]     o_drop_cnt;

  typedef struct { int x; int y; logic [7:0] v; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;

  always #5 CLK = ~CLK;

  frame_compositor #(
    .SCREEN_W(W), .SCREEN_H(H), .SPRITE_S(S), .SPRITE_COUNT(SC),
    .NUM_LAYERS(NL), .PIX_W(PW), .VRAM_AW(VAW), .SPR_AW(SAW)
  ) dut (
    .CLK(CLK), .rst(rst), .pix_stb(pix_stb), .i_x(i_x), .i_y(i_y),
    .i_active(i_active), .i_screenend(i_screenend), .i_bg_idx(i_bg_idx),
    .i_layer_en(i_layer_en), .i_layer_x(i_layer_x), .i_layer_y(i_layer_y),
    .i_layer_idx(i_layer_idx), .o_spr_addr(o_spr_addr), .i_spr_data(spr_data),
    .i_spr_alpha(spr_alpha), .o_pix_idx(o_pix_idx), .o_frame_valid(o_frame_valid),
    .o_busy(o_busy), .o_frame_drop(o_frame_drop), .o_drop_cnt(o_drop_cnt)
  );

  // Sprite ROM: 0 = r*32+c (alpha 0), 1 = solid 7, 2 = solid 9 opaque for c<16, 3 = solid 0x55
  function automatic logic [7:0] rom_data(input logic [SAW-1:0] a);
    case (a[12:10])
      3'd0:    return a[7:0];
      3'd1:    return 8'd7;
      3'd2:    return 8'd9;
      3'd3:    return 8'h55;
      default: return 8'hEE;
    endcase
  endfunction

  function automatic logic rom_alpha(input logic [SAW-1:0] a);
    case (a[12:10])
      3'd0:    return 1'b0;
      3'd2:    return (a[4:0] < 5'd16);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge CLK) begin
    spr_data  <= rom_data(o_spr_addr);
    spr_alpha <= rom_alpha(o_spr_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each strobe's fetch is shown on the following strobe.
  always @(posedge CLK) begin
    if (pix_stb && exp_q.size() >= 2) begin
      mon_e = exp_q.pop_front();
      #1;
      check($sformatf("pix(%0d,%0d)", mon_e.x, mon_e.y), 32'(o_pix_idx), 32'(mon_e.v));
    end
  end

  task automatic strobe(input int x, input int y, input logic act, input logic se,
                        input logic [7:0] ev);
    exp_t e;
    @(negedge CLK);
    i_x = 10'(x); i_y = 9'(y); i_active = act; i_screenend = se; pix_stb = 1'b1;
    e.x = x; e.y = y; e.v = ev;
    exp_q.push_back(e);
    @(negedge CLK);
    pix_stb = 1'b0; i_screenend = 1'b0; i_active = 1'b0;
  endtask

  task automatic scan(input int x, input int y, input logic [7:0] ev);
    strobe(x, y, 1'b1, 1'b0, ev);
  endtask

  task automatic swap();
    strobe(0, 0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic set_layer(input int k, input int x, input int y, input int idx);
    i_layer_en[k]           = 1'b1;
    i_layer_x[k*10 +: 10]   = 10'(x);
    i_layer_y[k*10 +: 10]   = 10'(y);
    i_layer_idx[k*3 +: 3]   = 3'(idx);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (o_busy && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_done"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pix_stb = 1'b0; i_x = '0; i_y = '0; i_active = 1'b0; i_screenend = 1'b0;
    i_bg_idx = '0; i_layer_en = '0; i_layer_x = '0; i_layer_y = '0; i_layer_idx = '0;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("rst_pix", 32'(o_pix_idx), 32'd0);
    check("rst_valid", 32'(o_frame_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_drop", 32'(o_frame_drop), 32'd0);
    check("rst_cnt", 32'(o_drop_cnt), 32'd0);
    check("rst_spr_addr", 32'(o_spr_addr), 32'd0);

    // Frame 1: background 0 plus layer 0 (sprite 1) at (10,20)
    set_layer(0, 10, 20, 1);
    swap();
    check("f1_busy", 32'(o_busy), 32'd1);
    check("f1_valid", 32'(o_frame_valid), 32'd0);
    scan(10, 20, 8'd0);
    wait_done("f1");
    check("f1_valid_after", 32'(o_frame_valid), 32'd0);
    scan(10, 20, 8'd0);

    // Frame 2: overlapping layers at (0,0) and a right-edge clipped layer at x=48
    i_layer_en = '0;
    set_layer(0, 0, 0, 1);
    set_layer(1, 0, 0, 2);
    set_layer(2, 48, 0, 3);
    swap();
    check("f2_valid", 32'(o_frame_valid), 32'd1);
    check("f2_busy", 32'(o_busy), 32'd1);
    check("f2_nodrop", 32'(o_frame_drop), 32'd0);
    scan(5, 33, 8'd37);
    scan(10, 20, 8'd7);
    scan(41, 51, 8'd7);
    scan(42, 20, 8'd138);
    scan(9, 20, 8'd137);
    scan(10, 52, 8'd138);
    scan(41, 19, 8'd105);
    scan(63, 63, 8'd255);
    strobe(10, 20, 1'b0, 1'b0, 8'd0);
    scan(10, 20, 8'd7);

    repeat (900) @(negedge CLK);
    swap();
    check("drop_pulse", 32'(o_frame_drop), 32'd1);
    check("drop_cnt1", 32'(o_drop_cnt), 32'd1);
    check("drop_busy", 32'(o_busy), 32'd1);
    @(negedge CLK);
    check("drop_pulse_end", 32'(o_frame_drop), 32'd0);
    scan(10, 20, 8'd7);
    scan(42, 20, 8'd138);
    wait_done("f2");
    check("drop_cnt_keep", 32'(o_drop_cnt), 32'd1);

    // Frame 3 has no layers; frame 2 goes on display
    i_layer_en = '0;
    swap();
    check("f3_valid", 32'(o_frame_valid), 32'd1);
    check("f3_busy", 32'(o_busy), 32'd1);
    scan(0, 0, 8'd9);
    scan(15, 10, 8'd9);
    scan(16, 0, 8'd7);
    scan(31, 31, 8'd7);
    scan(20, 1, 8'd7);
    scan(0, 1, 8'd9);
    scan(40, 3, 8'd104);
    scan(47, 0, 8'd15);
    scan(48, 0, 8'd85);
    scan(63, 31, 8'd85);
    scan(63, 32, 8'd31);
    scan(5, 32, 8'd5);

    // Drop counter saturation: 260 refused swaps while frame 3 composes
    for (int i = 0; i < 260; i++) begin
      exp_t e;
      @(negedge CLK);
      i_x = '0; i_y = '0; i_active = 1'b0; i_screenend = 1'b1; pix_stb = 1'b1;
      e.x = 0; e.y = 0; e.v = 8'd0;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    pix_stb = 1'b0; i_screenend = 1'b0;
    check("sat_cnt", 32'(o_drop_cnt), 32'd255);
    check("sat_drop", 32'(o_frame_drop), 32'd1);
    @(negedge CLK);
    check("sat_drop_end", 32'(o_frame_drop), 32'd0);
    wait_done("f3");
    scan(0, 1, 8'd9);
    strobe(0, 0, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
